// File: rtl/elastic_fifo_pkg.sv
// ---------------------------------------------------------------------------
// elastic_fifo_pkg
// Shared definitions for the elastic FIFO:
//   - cnt_width()  : width of the occupancy counter ($clog2(depth)+1)
//   - ptr_width()  : width of the read/write pointers ($clog2(depth))
//   - DROP_CNT_W   : width of the saturating drop counter (16)
//   - stats_t      : statistics record (drop counter + high-water mark)
// ---------------------------------------------------------------------------
package elastic_fifo_pkg;

    localparam int DROP_CNT_W = 16;
    // The high-water mark field is sized for the largest supported depth;
    // the top level exposes only the low cnt_width(DEPTH) bits.
    localparam int HWM_MAX_W  = 16;

    typedef struct packed {
        logic [DROP_CNT_W-1:0] drop_cnt;
        logic [HWM_MAX_W-1:0]  hwm;
    } stats_t;

    // Occupancy needs one extra bit so that "full" (== depth) is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Pointers index the storage array and wrap naturally (depth is 2^n).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/elastic_fifo_mem.sv
// ---------------------------------------------------------------------------
// elastic_fifo_mem
// DEPTH x WIDTH register-array storage, one synchronous write port and one
// asynchronous read port. The array is intentionally not reset: the FIFO
// control logic never exposes an entry that has not been written.
// Ports:
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  read data (combinational from the array)
// ---------------------------------------------------------------------------
module elastic_fifo_mem
    import elastic_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         we_i,
    input  logic [ptr_width(DEPTH)-1:0]  waddr_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic [ptr_width(DEPTH)-1:0]  raddr_i,
    output logic [WIDTH-1:0]             rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/elastic_fifo.sv
// ---------------------------------------------------------------------------
// elastic_fifo
// First-word-fall-through FIFO fed by a valid-only upstream (no backpressure).
// Beats arriving while full with no simultaneous pop are dropped and flagged
// by the sticky overflow bit. count/almost_full come from registers only.
//
// Optional feature: define ELASTIC_FIFO_STATS_EN to add the drop_cnt
// (saturating 16-bit drop counter) and hwm (high-water mark) outputs.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   in_vld       in   upstream valid strobe
//   in_data      in   upstream data
//   out_vld      out  head entry valid (count != 0)
//   out_rdy      in   downstream ready
//   out_data     out  head entry, zero when out_vld=0
//   count        out  current occupancy
//   almost_full  out  count >= AFULL_LVL
//   overflow     out  sticky: an input beat was dropped
//   clr_ovf      in   synchronous clear of overflow (and drop_cnt)
//   drop_cnt     out  [stats] saturating dropped-beat counter
//   hwm          out  [stats] maximum occupancy since reset
// ---------------------------------------------------------------------------
module elastic_fifo
    import elastic_fifo_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = DEPTH - 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_vld,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [WIDTH-1:0]             out_data,
    output logic [cnt_width(DEPTH)-1:0]  count,
    output logic                         almost_full,
    input  logic                         clr_ovf,
    output logic                         overflow
`ifdef ELASTIC_FIFO_STATS_EN
    ,
    output logic [DROP_CNT_W-1:0]        drop_cnt,
    output logic [cnt_width(DEPTH)-1:0]  hwm
`endif
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             afull_q, afull_d;
    logic             ovf_q, ovf_d;

    logic             out_vld_s;
    logic             push_s;
    logic             pop_s;
    logic             drop_s;
    logic [WIDTH-1:0] rd_data_s;

    // Handshake decode: a full FIFO still accepts a beat when it pops the same cycle
    always_comb begin
        out_vld_s = (count_q != {CW{1'b0}});
        pop_s     = out_vld_s & out_rdy;
        push_s    = in_vld & ((count_q != FULL_CNT) | pop_s);
        drop_s    = in_vld & ~push_s;
    end

    // Next-state for pointers, occupancy, almost_full and overflow
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase

        // almost_full is registered from the next count so it tracks count exactly
        afull_d = (count_d >= AFULL_CNT);

        // A drop in the same cycle as a clear keeps the flag set
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
        end
    end

    elastic_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (push_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data_s)
    );

    assign out_vld     = out_vld_s;
    assign out_data    = out_vld_s ? rd_data_s : {WIDTH{1'b0}};
    assign count       = count_q;
    assign almost_full = afull_q;
    assign overflow    = ovf_q;

`ifdef ELASTIC_FIFO_STATS_EN
    stats_t stats_q, stats_d;

    // Statistics next-state: saturating drop counter and high-water mark
    always_comb begin
        stats_d = stats_q;

        if (drop_s) begin
            if (clr_ovf) begin
                stats_d.drop_cnt = {{(DROP_CNT_W-1){1'b0}}, 1'b1};
            end else if (stats_q.drop_cnt != {DROP_CNT_W{1'b1}}) begin
                stats_d.drop_cnt = stats_q.drop_cnt + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stats_d.drop_cnt = stats_q.drop_cnt;
            end
        end else if (clr_ovf) begin
            stats_d.drop_cnt = {DROP_CNT_W{1'b0}};
        end else begin
            stats_d.drop_cnt = stats_q.drop_cnt;
        end

        if (HWM_MAX_W'(count_d) > stats_q.hwm) begin
            stats_d.hwm = HWM_MAX_W'(count_d);
        end else begin
            stats_d.hwm = stats_q.hwm;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stats_q <= '0;
        end else begin
            stats_q <= stats_d;
        end
    end

    assign drop_cnt = stats_q.drop_cnt;
    assign hwm      = stats_q.hwm[CW-1:0];
`endif

endmodule

// File: doc/elastic_fifo.md
ELASTIC_FIFO -- requirements
Module: elastic_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data bit width.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning entry count (power of two, >= 2).
REQ-003 The block SHALL have parameter AFULL_LVL, default DEPTH-4, meaning the occupancy at which almost_full asserts (1..DEPTH).
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_vld  input  1  upstream valid-only strobe (no backpressure).
REQ-007 in_data  input  WIDTH  upstream data, sampled when in_vld=1.
REQ-008 out_vld  output  1  downstream valid.
REQ-009 out_rdy  input  1  downstream ready.
REQ-010 out_data  output  WIDTH  head-of-queue data.
REQ-011 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 almost_full  output  1  count >= AFULL_LVL; upstream throttle hint.
REQ-013 overflow  output  1  sticky flag: an input beat was dropped.
REQ-014 clr_ovf  input  1  synchronous clear of overflow.

Function
REQ-015 Push SHALL occur when in_vld=1 and (count<DEPTH or pop occurs the same cycle).
REQ-016 Pop SHALL occur when out_vld=1 and out_rdy=1.
REQ-017 out_vld SHALL equal (count!=0); first-word-fall-through, no combinational in->out bypass.
REQ-018 A beat pushed in cycle N SHALL be visible on out_vld/out_data at cycle N+1 at the earliest.
REQ-019 out_data SHALL equal the oldest entry when out_vld=1 and SHALL be all-zeros when out_vld=0.
REQ-020 Push+pop same cycle SHALL leave count unchanged; at full this is legal and loses no data.
REQ-021 in_vld=1 at count=DEPTH without pop SHALL discard in_data, leave FIFO contents unchanged, and set overflow from the next cycle.
REQ-022 Pop at count=0 SHALL be impossible (out_vld=0); out_rdy while empty SHALL have no effect.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; order SHALL be strictly FIFO.
REQ-024 almost_full and count SHALL be driven from registered state only (no in_vld/out_rdy combinational path).
REQ-025 overflow SHALL clear on clr_ovf=1; a drop in the same cycle as clr_ovf SHALL win (overflow stays 1).

Reset
REQ-026 rst_n=0 SHALL immediately force count=0, pointers=0, out_vld=0, out_data=0, almost_full=0, overflow=0.
REQ-027 Reset mid-operation SHALL discard all queued entries; storage array contents need not be cleared.
REQ-028 First push SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro ELASTIC_FIFO_STATS_EN SHALL, when defined, add outputs drop_cnt (16 bit, saturating at 0xFFFF, increments per dropped beat, cleared by clr_ovf unless a drop coincides, then =1) and hwm ($clog2(DEPTH)+1 bit, maximum count reached since reset), both reset to 0.
REQ-030 Without ELASTIC_FIFO_STATS_EN these ports and counters SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-031 Package elastic_fifo_pkg SHALL hold the pointer/count width function, the drop_cnt width constant (16), and the stats-record typedef.
REQ-032 Storage SHALL be a sub-module elastic_fifo_mem (DEPTH x WIDTH register array, one write port, one async read port, no reset).

Verification
REQ-033 Reset, then 3 pushes 0xA,0xB,0xC with out_rdy=0 -> count=3, out_vld=1, out_data=0xA; then out_rdy=1 for 3 cycles -> pops 0xA,0xB,0xC, count=0, out_data=0.
REQ-034 DEPTH=8, 9 consecutive pushes 1..9, out_rdy=0 -> count=8, almost_full=1 from count=4, beat 9 dropped, overflow=1, drain yields 1..8.
REQ-035 Full FIFO, in_vld=1 and out_rdy=1 for 20 cycles with incrementing data -> count stays 8, no overflow, output sequence contiguous.
REQ-036 clr_ovf=1 in the same cycle as a drop -> overflow remains 1; clr_ovf alone next cycle -> overflow=0.
REQ-037 rst_n pulsed low with count=5 -> out_vld=0, count=0 during reset; post-reset push 0x55 -> out_data=0x55 next cycle.
REQ-038 With ELASTIC_FIFO_STATS_EN, 70000 drops -> drop_cnt=0xFFFF, hwm=8; clr_ovf -> drop_cnt=0, hwm unchanged.
